vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen.sv | 158 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source for the 800x600 VGA path: colour bars, grid, gradient and bouncing box.
// Optional build macro PATTERN_BORDER_EN forces a white one-pixel frame border over every pattern.
`timescale 1ns/1ps
module vga_pattern_gen #(
  parameter int H_ACT      = 800,
  parameter int V_ACT      = 600,
  parameter int BOX_SIZE   = 64,
  parameter int BOX_STEP   = 2,
  parameter int GRID_SHIFT = 5,
  parameter logic [7:0] BOX_COLOR = 8'hE0
) (
  input  logic        CLK_40M,
  input  logic        RST,
  input  logic        KEY_MODE,
  input  logic        FRAME_START,
  input  logic        PIX_DE,
  input  logic [10:0] PIX_X,
  input  logic [9:0]  PIX_Y,
  output logic [7:0]  PAT_DATA,
  output logic        PAT_DE,
  output logic [1:0]  MODE
);

  localparam int BAR_W = H_ACT / 8;
  localparam logic [11:0] X_MAX  = 12'(H_ACT - BOX_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(V_ACT - BOX_SIZE);
  localparam logic [11:0] STEP   = 12'(BOX_STEP);
  localparam logic [11:0] SIZE   = 12'(BOX_SIZE);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t      r_state;
  logic [1:0]  r_mode;
  logic [11:0] r_box_x, r_box_y;
  logic        r_dir_x, r_dir_y;   // 1 = moving toward larger coordinates
  logic [7:0]  r_pat_data;
  logic        r_pat_de;

  logic [11:0] w_x12, w_y12;
  logic [2:0]  w_bar_idx;
  logic [7:0]  w_bar_col, w_grid_col, w_grad_col, w_box_col, w_pix;

  assign w_x12 = {1'b0, PIX_X};
  assign w_y12 = {2'b0, PIX_Y};

  // Bar index by threshold compares; anything past the last boundary stays at 7.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++)
      if (w_x12 >= 12'(k * BAR_W)) w_bar_idx = 3'(k);
  end

  always_comb begin
    case (w_bar_idx)
      3'd0:    w_bar_col = 8'hFF;
      3'd1:    w_bar_col = 8'hFC;
      3'd2:    w_bar_col = 8'h1F;
      3'd3:    w_bar_col = 8'h1C;
      3'd4:    w_bar_col = 8'hE3;
      3'd5:    w_bar_col = 8'hE0;
      3'd6:    w_bar_col = 8'h03;
      default: w_bar_col = 8'h00;
    endcase
  end

  assign w_grid_col = ((PIX_X[GRID_SHIFT-1:0] == '0) || (PIX_Y[GRID_SHIFT-1:0] == '0)) ? 8'hFF : 8'h00;
  assign w_grad_col = {PIX_X[9:7], PIX_Y[9:7], PIX_X[6:5]};
  assign w_box_col  = ((w_x12 >= r_box_x) && (w_x12 < r_box_x + SIZE) &&
                       (w_y12 >= r_box_y) && (w_y12 < r_box_y + SIZE)) ? BOX_COLOR : 8'h00;

  always_comb begin
    w_pix = 8'h00;
    if (PIX_DE) begin
      case (r_mode)
        2'd0:    w_pix = w_bar_col;
        2'd1:    w_pix = w_grid_col;
        2'd2:    w_pix = w_grad_col;
        default: w_pix = w_box_col;
      endcase
`ifdef PATTERN_BORDER_EN
      if ((w_x12 == 12'd0) || (w_x12 == 12'(H_ACT - 1)) ||
          (w_y12 == 12'd0) || (w_y12 == 12'(V_ACT - 1)))
        w_pix = 8'hFF;
`endif
    end
  end

  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      r_pat_data <= 8'h00;
      r_pat_de   <= 1'b0;
    end else begin
      r_pat_data <= w_pix;
      r_pat_de   <= PIX_DE;
    end
  end

  // Mode only advances on a frame boundary so a frame is never split between patterns.
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_mode  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (FRAME_START) begin
            if (KEY_MODE) r_mode <= r_mode + 2'd1;
          end else if (KEY_MODE) begin
            r_state <= S_PEND;
          end
        end
        default: begin
          if (FRAME_START) begin
            r_mode  <= r_mode + 2'd1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      r_box_x <= '0;
      r_box_y <= '0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (FRAME_START) begin
      if (r_dir_x) begin
        if (r_box_x + STEP > X_MAX) begin
          r_box_x <= X_MAX;
          r_dir_x <= 1'b0;
        end else r_box_x <= r_box_x + STEP;
      end else begin
        if (r_box_x < STEP) begin
          r_box_x <= '0;
          r_dir_x <= 1'b1;
        end else r_box_x <= r_box_x - STEP;
      end
      if (r_dir_y) begin
        if (r_box_y + STEP > Y_MAX) begin
          r_box_y <= Y_MAX;
          r_dir_y <= 1'b0;
        end else r_box_y <= r_box_y + STEP;
      end else begin
        if (r_box_y < STEP) begin
          r_box_y <= '0;
          r_dir_y <= 1'b1;
        end else r_box_y <= r_box_y - STEP;
      end
    end
  end

  assign PAT_DATA = r_pat_data;
  assign PAT_DE   = r_pat_de;
  assign MODE     = r_mode;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: every-cycle compare against a behavioural frame/pixel model, plus literal pins.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key = 1'b0, fs = 1'b0, de = 1'b0;
  logic [10:0] px = '0;
  logic [9:0]  py = '0;
  logic [7:0]  pat_data;
  logic        pat_de;
  logic [1:0]  mode;

  int n_chk = 0, n_fail = 0;

  // behavioural model state
  int m_mode, m_bx, m_by, m_dx, m_dy;
  bit m_pend;
  logic [7:0] e_data;
  logic       e_de;

  vga_pattern_gen dut (
    .CLK_40M(clk), .RST(rst), .KEY_MODE(key), .FRAME_START(fs), .PIX_DE(de),
    .PIX_X(px), .PIX_Y(py), .PAT_DATA(pat_data), .PAT_DE(pat_de), .MODE(mode)
  );

  always #12.5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pix(input int x, input int y, input int md, input int bx, input int by);
    logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    int idx;
    logic [7:0] r;
    case (md)
      0: begin idx = x / 100; if (idx > 7) idx = 7; r = bars[idx]; end
      1: r = ((x % 32 == 0) || (y % 32 == 0)) ? 8'hFF : 8'h00;
      2: r = 8'(((x / 128) % 8) * 32 + ((y / 128) % 8) * 4 + (x / 32) % 4);
      default: r = (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 8'hE0 : 8'h00;
    endcase
`ifdef PATTERN_BORDER_EN
    if (x == 0 || x == 799 || y == 0 || y == 599) r = 8'hFF;
`endif
    return r;
  endfunction

  function automatic void move(inout int p, inout int d, input int pmax);
    if (d > 0) begin
      if (p + 2 > pmax) begin p = pmax; d = -1; end else p = p + 2;
    end else begin
      if (p < 2) begin p = 0; d = 1; end else p = p - 2;
    end
  endfunction

  // single compare process: predict from the inputs seen at the edge, check just after it
  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pend = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
      e_data = 8'h00; e_de = 1'b0;
    end else begin
      e_data = de ? model_pix(int'(px), int'(py), m_mode, m_bx, m_by) : 8'h00;
      e_de   = de;
      if (fs) begin
        if (m_pend || key) m_mode = (m_mode + 1) % 4;
        m_pend = 0;
        move(m_bx, m_dx, 736);
        move(m_by, m_dy, 536);
      end else if (key) m_pend = 1;
    end
    #1;
    chk("pat_data", int'(pat_data), int'(e_data));
    chk("pat_de", int'(pat_de), int'(e_de));
    chk("mode", int'(mode), m_mode);
  end

  task automatic drive(input bit k, input bit f, input bit d, input int x, input int y);
    @(negedge clk);
    key = k; fs = f; de = d; px = 11'(x); py = 10'(y);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic pix_lit(input string name, input int x, input int y, input int exp);
    drive(0, 0, 1, x, y);
    @(negedge clk);
    chk(name, int'(pat_data), exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
  endtask

  initial begin
    int x, y;
    idle(); idle();
    #1 chk("reset_data", int'(pat_data), 0);
    chk("reset_mode", int'(mode), 0);
    rst = 1'b0;

    // colour bars across one full line
    for (int i = 0; i < 800; i++) drive(0, 0, 1, i, 0);
    idle();
    pix_lit("bar_x0", 0, 0, 8'hFF);
    pix_lit("bar_x99", 99, 0, 8'hFF);
    pix_lit("bar_x100", 100, 0, 8'hFC);
    pix_lit("bar_x450", 450, 0, 8'hE3);
    pix_lit("bar_x799", 799, 0, 8'h00);

    // randomized traffic: keys, frame starts, pixels (some aimed at the box)
    for (int i = 0; i < 3000; i++) begin
      bit d;
      d = ($urandom % 4) != 0;
      if (d && ($urandom % 2 == 0)) begin
        x = m_bx + int'($urandom % 80) - 8; if (x < 0) x = 0; if (x > 799) x = 799;
        y = m_by + int'($urandom % 80) - 8; if (y < 0) y = 0; if (y > 599) y = 599;
      end else if (d) begin
        x = int'($urandom % 800); y = int'($urandom % 600);
      end else begin
        x = int'($urandom % 2048); y = int'($urandom % 1024);
      end
      drive(($urandom % 40) == 0, ($urandom % 200) == 0, d, x, y);
    end

    // FSM: coincident key + frame start increments at once
    do_reset();
    drive(1, 1, 0, 0, 0); idle();
    chk("mode_coincident", int'(mode), 1);
    pix_lit("grid_31_5", 31, 5, 8'h00);
    pix_lit("grid_32_5", 32, 5, 8'hFF);
    pix_lit("grid_10_64", 10, 64, 8'hFF);
    // three keys in one frame give a single increment
    drive(1, 0, 0, 0, 0); idle(); drive(1, 0, 0, 0, 0); idle(); drive(1, 0, 0, 0, 0); idle();
    chk("mode_pending_hold", int'(mode), 1);
    drive(0, 1, 0, 0, 0); idle(); idle();
    chk("mode_absorb", int'(mode), 2);
    pix_lit("grad_700_500", 700, 500, 8'hAD);

    // async reset mid-line
    #3 rst = 1'b1;
    #1 chk("async_rst_data", int'(pat_data), 0);
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_de", int'(pat_de), 0);
    idle(); idle();
    rst = 1'b0;

    // box motion from reset: 368 frames, mode 3 after three coincident increments
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 0, 0); idle(); end
    chk("mode_three", int'(mode), 3);
    for (int i = 0; i < 365; i++) begin drive(0, 1, 0, 0, 0); idle(); end
    chk("model_bx_368", m_bx, 736);
    chk("model_by_368", m_by, 338);
    pix_lit("box_in_tl", 736, 338, 8'hE0);
    pix_lit("box_left_out", 735, 338, 8'h00);
    pix_lit("box_in_br", 799, 401, 8'hE0);
    pix_lit("box_below_out", 736, 402, 8'h00);
`ifdef PATTERN_BORDER_EN
    pix_lit("border_0_300", 0, 300, 8'hFF);
    pix_lit("border_799_300", 799, 300, 8'hFF);
    pix_lit("border_400_599", 400, 599, 8'hFF);
    pix_lit("border_1_300", 1, 300, 8'h00);
`endif
    drive(0, 1, 0, 0, 0); idle();
    chk("model_bx_369", m_bx, 736);
    drive(0, 1, 0, 0, 0); idle();
    chk("model_bx_370", m_bx, 734);
    chk("model_by_370", m_by, 334);
    pix_lit("box_moved_left", 798, 334, 8'h00);
    pix_lit("box_moved_in", 734, 334, 8'hE0);

    // fourth increment wraps to mode 0
    drive(1, 1, 0, 0, 0); idle();
    chk("mode_wrap", int'(mode), 0);
    drive(0, 0, 0, 50, 10); @(negedge clk);
    chk("de_low_data", int'(pat_data), 0);
    chk("de_low_de", int'(pat_de), 0);
    for (int i = 0; i < 50; i++) drive(0, 0, 0, int'($urandom % 2048), int'($urandom % 1024));
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
